operand_sequencer: RTL

- Sequential front-end for the 8-bit bitwise XOR unit.
- Collects two signed 8-bit operands from a shared byte bus (A, then B) and presents them registered and stable to the combinational XOR unit for one execute cycle.
- Captures the unit's result with status flags and holds it on a valid/ready output until consumed.
- Sits directly upstream of the XOR unit and directly downstream of it: it drives the unit's inputs and registers its output.

---
 rtl/operand_sequencer_pkg.sv | 26 ++
 rtl/operand_sequencer_if.sv | 27 ++
 rtl/operand_sequencer_result_flags.sv | 14 +
 rtl/operand_sequencer.sv | 110 +++++++++++
 4 files changed

// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: state encoding, default sizes
// and the registered status-flag bundle.
package operand_sequencer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] ST_LOAD_A = 2'd0;
    localparam logic [1:0] ST_LOAD_B = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        LOAD_A = ST_LOAD_A,
        LOAD_B = ST_LOAD_B,
        EXEC   = ST_EXEC,
        HOLD   = ST_HOLD
    } state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic par;
    } flags_t;

endpackage

// File: rtl/operand_sequencer_if.sv
// Operand byte bus and result valid/ready channel of the operand sequencer.
// The sequencer takes the slave view; its environment takes the master view.
interface operand_sequencer_if
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] res_out;
    logic             res_valid;
    logic             res_ready;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_par;

    modport master (
        output din, din_valid, res_ready,
        input  din_ready, res_out, res_valid, flag_zero, flag_neg, flag_par
    );

    modport slave (
        input  din, din_valid, res_ready,
        output din_ready, res_out, res_valid, flag_zero, flag_neg, flag_par
    );
endinterface

// File: rtl/operand_sequencer_result_flags.sv
// Purely combinational status flags of a WIDTH-bit two's complement result:
// zero, sign and odd parity.
module result_flags #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             neg,
    output logic             par
);
    assign zero = (res == '0);
    assign neg  = res[WIDTH-1];
    assign par  = ^res;
endmodule

// File: rtl/operand_sequencer.sv
// Sequential front-end for the XOR unit: loads A then B from a shared byte bus,
// gives the unit one execute cycle, then holds the registered result until consumed.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    operand_sequencer_if.slave bus,
    output logic [WIDTH-1:0]  op_a,
    output logic [WIDTH-1:0]  op_b,
    input  logic [WIDTH-1:0]  res_in,
    output logic [CNT_W-1:0]  op_count
);

    state_t           state;
    state_t           next_state;
    logic             din_hs;
    logic             load_a;
    logic             load_b;
    logic             capture;
    logic             consume;
    flags_t           res_flags;
    flags_t           flags_q;
    logic [WIDTH-1:0] res_q;
    logic             valid_q;

    result_flags #(.WIDTH(WIDTH)) u_result_flags (
        .res  (res_in),
        .zero (res_flags.zero),
        .neg  (res_flags.neg),
        .par  (res_flags.par)
    );

    assign bus.din_ready = (state == LOAD_A) || (state == LOAD_B);
    assign din_hs        = bus.din_valid && bus.din_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        capture    = 1'b0;
        consume    = 1'b0;
        // abort overrides any handshake seen in the same cycle
        if (abort) begin
            next_state = LOAD_A;
        end else begin
            unique case (state)
                LOAD_A: if (din_hs) begin
                    load_a     = 1'b1;
                    next_state = LOAD_B;
                end
                LOAD_B: if (din_hs) begin
                    load_b     = 1'b1;
                    next_state = EXEC;
                end
                EXEC: begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
                HOLD: if (bus.res_ready) begin
                    consume    = 1'b1;
                    next_state = LOAD_A;
                end
                default: next_state = LOAD_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD_A;
        else        state <= next_state;
    end

    // Flags are reset to zero rather than derived from the cleared result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
            op_count <= '0;
        end else begin
            if (load_a) op_a <= bus.din;
            if (load_b) op_b <= bus.din;
            if (capture) begin
                res_q   <= res_in;
                flags_q <= res_flags;
            end
            if (consume) op_count <= op_count + CNT_W'(1);

            if (abort)        valid_q <= 1'b0;
            else if (capture) valid_q <= 1'b1;
            else if (consume) valid_q <= 1'b0;
        end
    end

    assign bus.res_out   = res_q;
    assign bus.res_valid = valid_q;
    assign bus.flag_zero = flags_q.zero;
    assign bus.flag_neg  = flags_q.neg;
    assign bus.flag_par  = flags_q.par;

endmodule
